// File: rtl/aes_128_inv.sv
// aes_128_inv: iterative AES-128 decryptor, one round per clock.
// Expands the key forward to round key 10, then decrypts while
// walking the key schedule backwards.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  request, sampled only while idle
//   key    128-bit cipher key (byte 0 in the MSBs)
//   in     128-bit ciphertext, captured with key on the accepted start
//   busy   high from the edge after acceptance until done rises
//   done   one-cycle pulse, out valid in that cycle
//   out    128-bit plaintext, held until the next done
//
// KEY_CACHE=1 lets a repeated key skip the expansion phase.
module aes_128_inv #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] in,
    output logic         busy,
    output logic         done,
    output logic [127:0] out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] EXPAND  = 2'd1;
    localparam logic [1:0] DECRYPT = 2'd2;
    localparam logic [1:0] FINISH  = 2'd3;

    // GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; 0 maps to 0
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] p;
        sq = x;
        p  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            p  = gmul(p, sq);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = ginv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] isbox(input logic [7:0] s);
        logic [7:0] v;
        v = {s[6:0], s[7]} ^ {s[4:0], s[7:5]}
          ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(v);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]),
                sbox(w[7:0]),   sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] t, n0, n1, n2, n3;
        t  = subrot(k[31:0]) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Undo one schedule step: the last word of the previous round key
    // must be recovered first because the first word depends on it.
    function automatic logic [127:0] key_inv(
        input logic [127:0] k,
        input logic [7:0]   rc
    );
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ subrot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_round(
        input logic [127:0] s,
        input logic [127:0] rk,
        input logic         last
    );
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        // row r rotates right by r columns, then bytes are inverted
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] =
                    isbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        t = t ^ rk;
        m = t;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8];
            a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8];
            a3 = t[103-32*c -: 8];
            m[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                             ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            m[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                             ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            m[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                             ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            m[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                             ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return last ? t : m;
    endfunction

    logic [1:0]   fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] kr;
    logic [127:0] kq;
    logic [127:0] ckey;
    logic [127:0] crk;
    logic         cvld;

    logic [127:0] fwd_k;
    logic [127:0] inv_k;
    logic [127:0] dec_nx;
    logic [3:0]   rdec;
    logic         last;
    logic         hit;

    // In DECRYPT the counter runs up while the round index r runs down,
    // so r = 9 - cnt; rk_r uses Rcon[r+1], which is table entry r.
    always_comb begin
        rdec   = 4'd9 - cnt;
        last   = (cnt == 4'd9);
        fwd_k  = key_fwd(kr, rcon(cnt));
        inv_k  = key_inv(kr, rcon(rdec));
        dec_nx = inv_round(st, inv_k, last);
        hit    = (KEY_CACHE != 0) && cvld && (key == ckey);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm  <= IDLE;
            cnt  <= 4'd0;
            st   <= '0;
            kr   <= '0;
            kq   <= '0;
            ckey <= '0;
            crk  <= '0;
            cvld <= 1'b0;
            out  <= '0;
            busy <= 1'b0;
        end else begin
            busy <= (fsm == EXPAND) ||
                    ((fsm == DECRYPT) && !last);
            unique case (fsm)
                IDLE: begin
                    if (start) begin
                        cnt <= 4'd0;
                        kq  <= key;
                        if (hit) begin
                            st  <= in ^ crk;
                            kr  <= crk;
                            fsm <= DECRYPT;
                        end else begin
                            st  <= in;
                            kr  <= key;
                            fsm <= EXPAND;
                        end
                    end
                end
                EXPAND: begin
                    kr <= fwd_k;
                    if (cnt == 4'd9) begin
                        st   <= st ^ fwd_k;
                        ckey <= kq;
                        crk  <= fwd_k;
                        cvld <= 1'b1;
                        cnt  <= 4'd0;
                        fsm  <= DECRYPT;
                    end else if (cnt < 4'd9) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DECRYPT: begin
                    kr <= inv_k;
                    st <= dec_nx;
                    if (last) begin
                        out <= dec_nx;
                        fsm <= FINISH;
                    end else if (cnt < 4'd9) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                FINISH: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    assign done = (fsm == FINISH);

endmodule

// File: tb/tb_aes_128_inv.sv
// tb_aes_128_inv: checks aes_128_inv against a byte-level AES-128
// encryptor model, FIPS-197 vectors and random loop-back pairs.
module tb_aes_128_inv;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [127:0] din;
    logic         busy1, done1, busy0, done0;
    logic [127:0] out1, out0;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb [256];
    logic         cvld;
    logic [127:0] ckey;
    logic [127:0] last_pt;

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CTC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;

    aes_128_inv #(.KEY_CACHE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .key(key), .in(din),
        .busy(busy1), .done(done1), .out(out1)
    );

    aes_128_inv #(.KEY_CACHE(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .key(key), .in(din),
        .busy(busy0), .done(done0), .out(out0)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box by exhaustive inverse search plus the bitwise affine map
    task automatic build_sbox();
        logic [7:0] v, b, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            v = 0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8]
                     ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
            sb[x] = b;
        end
    endtask

    function automatic logic [127:0] enc(input logic [127:0] k,
                                         input logic [127:0] p);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, t0, a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                t0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[t0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1];
                a2 = t[4*c+2]; a3 = t[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1;
                    s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*rd+i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One decrypt; with hold, start stays high (and in/key are
    // scrambled) through the FINISH edge to show it is not queued.
    task automatic op(input logic [127:0] k, input logic [127:0] ct,
                      input logic [127:0] pt, input bit hold,
                      input string tag);
        int lat1, lat0, nd1, nd0, nb1, ovl, exp1;
        logic [127:0] o1, o0, mid;
        exp1 = (cvld && k == ckey) ? 10 : 20;
        lat1 = -1; lat0 = -1; nd1 = 0; nd0 = 0; nb1 = 0; ovl = 0;
        o1 = '0; o0 = '0; mid = '0;
        @(negedge clk);
        key = k; din = ct; start = 1'b1;
        for (int n = 0; n <= 45; n++) begin
            @(negedge clk);
            if (done1) begin
                nd1++;
                if (lat1 < 0) begin lat1 = n; o1 = out1; end
            end
            if (done0) begin
                nd0++;
                if (lat0 < 0) begin lat0 = n; o0 = out0; end
            end
            if (busy1) nb1++;
            if (busy1 && done1) ovl++;
            if (busy0 && done0) ovl++;
            if (n == 3) mid = out1;
            if (!hold && n == 0) start = 1'b0;
            if (hold && n == 0) begin
                din = {16{8'haa}};
                key = ~k;
            end
            if (hold && lat1 >= 0 && n == lat1 + 1) start = 1'b0;
            if (lat1 >= 0 && lat0 >= 0 && n >= lat1 + 3 && n >= lat0 + 2)
                break;
        end
        start = 1'b0;
        chk({tag, "_out"}, o1, pt);
        chk({tag, "_out_nc"}, o0, pt);
        chk({tag, "_lat"}, 128'(lat1), 128'(exp1));
        chk({tag, "_lat_nc"}, 128'(lat0), 128'd20);
        chk({tag, "_ndone"}, 128'(nd1), 128'd1);
        chk({tag, "_ndone_nc"}, 128'(nd0), 128'd1);
        chk({tag, "_busy"}, 128'(nb1), 128'(exp1 - 1));
        chk({tag, "_overlap"}, 128'(ovl), 128'd0);
        chk({tag, "_hold"}, mid, last_pt);
        cvld = 1'b1;
        ckey = k;
        last_pt = pt;
    endtask

    task automatic rst_mid();
        logic [127:0] k, p;
        int nd;
        k = rnd128();
        p = rnd128();
        @(negedge clk);
        key = k; din = enc(k, p); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 128'(busy1), 128'd0);
        chk("rst_done", 128'(done1), 128'd0);
        chk("rst_out", out1, 128'd0);
        chk("rst_out_nc", out0, 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done1 || done0) nd++;
        end
        chk("rst_nodone", 128'(nd), 128'd0);
        cvld = 1'b0;
        last_pt = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] k, p;
        reset = 1'b0;
        start = 1'b0;
        key = '0;
        din = '0;
        cvld = 1'b0;
        ckey = '0;
        last_pt = '0;
        build_sbox();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 128'(busy1), 128'd0);
        chk("reset_done", 128'(done1), 128'd0);
        chk("reset_out", out1, 128'd0);
        @(negedge clk);
        reset = 1'b1;
        chk("model_b", enc(KB, PTB), CTB);
        op(KB, CTB, PTB, 1'b0, "appb");
        op(KC, CTC, PTC, 1'b0, "c1");
        op(KC, CTC, PTC, 1'b0, "c1hit");
        op(KB, CTB, PTB, 1'b0, "appb2");
        op(KB, CTB, PTB, 1'b1, "hold");
        rst_mid();
        op(KB, CTB, PTB, 1'b0, "postrst");
        k = rnd128();
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(3) != 0) k = rnd128();
            p = rnd128();
            op(k, enc(k, p), p, 1'b0, "loop");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
